// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 engine: word and block widths, the state
// encoding of the message-schedule FSM, the round-constant table K[0:63] and a
// helper that extracts big-endian message word M_i from a 512-bit block.
// -----------------------------------------------------------------------------
package sha256_pkg;

   localparam int SHA256_WORDSIZE = 32;
   localparam int BLOCK_WIDTH     = 512;
   localparam int SCHED_WINDOW    = 16;

   localparam logic STATE_IDLE_ENC = 1'b0;
   localparam logic STATE_RUN_ENC  = 1'b1;

   typedef enum logic {
      IDLE = STATE_IDLE_ENC,
      RUN  = STATE_RUN_ENC
   } sched_state_e;

   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // M0 sits in the most significant word of the block.
   function automatic logic [SHA256_WORDSIZE-1:0] block_word(
      input logic [BLOCK_WIDTH-1:0] blk,
      input int                     i
   );
      return blk[BLOCK_WIDTH-1-SHA256_WORDSIZE*i -: SHA256_WORDSIZE];
   endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched_if
// Block-in / schedule-word-out handshake bundle of the message scheduler.
//   blk_valid/blk_ready/blk_data : 512-bit padded block, upstream -> scheduler
//   w_valid/w_ready               : schedule stream handshake, scheduler -> round
//   w_data/k_data/w_idx/w_last    : Wt, Kt, t and (t == 63) for the round datapath
// Modports:
//   master : the scheduler (produces the W/K stream, accepts blocks)
//   slave  : the environment (offers blocks, consumes the W/K stream)
// -----------------------------------------------------------------------------
interface sha256_msg_sched_if;
   import sha256_pkg::*;

   logic                       blk_valid;
   logic                       blk_ready;
   logic [BLOCK_WIDTH-1:0]     blk_data;

   logic                       w_valid;
   logic                       w_ready;
   logic [SHA256_WORDSIZE-1:0] w_data;
   logic [SHA256_WORDSIZE-1:0] k_data;
   logic [5:0]                 w_idx;
   logic                       w_last;

   modport master (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_data, k_data, w_idx, w_last
   );

   modport slave (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_data, k_data, w_idx, w_last
   );

endinterface

// File: rtl/sha256_sched_sigma.sv
// -----------------------------------------------------------------------------
// sha256_sched_sigma
// Combinational small sigmas of the SHA-256 message schedule.
//   s0_in  / s0_out : sigma0(x) = ROTR7(x)  ^ ROTR18(x) ^ SHR3(x)
//   s1_in  / s1_out : sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
// -----------------------------------------------------------------------------
module sha256_sched_sigma
   import sha256_pkg::*;
(
   input  logic [SHA256_WORDSIZE-1:0] s0_in,
   input  logic [SHA256_WORDSIZE-1:0] s1_in,
   output logic [SHA256_WORDSIZE-1:0] s0_out,
   output logic [SHA256_WORDSIZE-1:0] s1_out
);

   assign s0_out = {s0_in[6:0],  s0_in[31:7]}
                 ^ {s0_in[17:0], s0_in[31:18]}
                 ^ {3'b000,      s0_in[31:3]};

   assign s1_out = {s1_in[16:0], s1_in[31:17]}
                 ^ {s1_in[18:0], s1_in[31:19]}
                 ^ {10'b0,       s1_in[31:10]};

endmodule

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
// Message-schedule generator: accepts one padded 512-bit block and streams
// W0..W63 together with K0..K63 to the round datapath, one pair per handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : sha256_msg_sched_if.master (block input + W/K output stream)
// A 16-word sliding window holds W[t..t+15]; win[0] is the word on the output.
// Each accepted word shifts the window and appends W[t+16], computed
// combinationally from the registered window.
// -----------------------------------------------------------------------------
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int WORDSIZE = SHA256_WORDSIZE,  // only 32 is supported
   parameter int ROUNDS   = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   sha256_msg_sched_if.master        bus
);

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   sched_state_e        state_q, state_d;
   logic [5:0]          idx_q,   idx_d;
   logic [WORDSIZE-1:0] win_q [SCHED_WINDOW];
   logic [WORDSIZE-1:0] win_d [SCHED_WINDOW];

   logic [WORDSIZE-1:0] sig0, sig1, w_next;
   logic                blk_fire, w_fire, at_last;

   sha256_sched_sigma u_sigma (
      .s0_in  (win_q[1]),
      .s1_in  (win_q[14]),
      .s0_out (sig0),
      .s1_out (sig1)
   );

   // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], wrapping mod 2^32.
   assign w_next = sig1 + win_q[9] + sig0 + win_q[0];

   assign bus.blk_ready = (state_q == IDLE);
   assign bus.w_valid   = (state_q == RUN);
   assign bus.w_data    = win_q[0];
   assign bus.k_data    = K_TABLE[idx_q];
   assign bus.w_idx     = idx_q;
   assign bus.w_last    = (state_q == RUN) && at_last;

   assign at_last  = (idx_q == LAST_IDX);
   assign blk_fire = bus.blk_valid && bus.blk_ready;
   assign w_fire   = bus.w_valid && bus.w_ready;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch can be inferred.
      state_d = state_q;
      idx_d   = idx_q;
      win_d   = win_q;

      unique case (state_q)
         IDLE: begin
            if (blk_fire) begin
               for (int i = 0; i < SCHED_WINDOW; i++) begin
                  win_d[i] = block_word(bus.blk_data, i);
               end
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (w_fire) begin
               if (at_last) begin
                  // Window contents are stale from here on; the next block
                  // reloads all 16 words, so they are left as they are.
                  state_d = IDLE;
               end else begin
                  for (int i = 0; i < SCHED_WINDOW - 1; i++) begin
                     win_d[i] = win_q[i+1];
                  end
                  win_d[SCHED_WINDOW-1] = w_next;
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         // NOTE: the window is reset (not left as storage) because win[0]
         // drives w_data directly and must read as zero out of reset.
         for (int i = 0; i < SCHED_WINDOW; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         win_q   <= win_d;
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_sched
// Directed bench for the SHA-256 message scheduler: reset values, the "abc"
// block with hand-derived words, backpressure, back-to-back blocks, reset in
// mid-block and blk_valid activity during RUN. Expected schedule words come
// from an array-form reference of the SHA-256 recurrence.
// -----------------------------------------------------------------------------
module tb_sha256_msg_sched;

   logic clk;
   logic rst;

   sha256_msg_sched_if bus ();

   sha256_msg_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   logic [31:0] k_ref [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [31:0]  exp_w [64];
   logic [31:0]  got_w [64];
   logic [511:0] blk_abc, blk_a, blk_b, blk_c, blk_d;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

   task automatic build_exp(input logic [511:0] blk);
      for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b = '0;
      for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
      return b;
   endfunction

   // Offers a block from IDLE and checks W0 appears one cycle after acceptance.
   task automatic send_block(input logic [511:0] blk);
      build_exp(blk);
      @(negedge clk);
      check("idle_blk_ready", bus.blk_ready, 1);
      bus.w_ready   = 1'b0;
      bus.blk_data  = blk;
      bus.blk_valid = 1'b1;
      @(posedge clk);
      #1 bus.blk_valid = 1'b0;
      @(negedge clk);
      check("lat_w_valid", bus.w_valid, 1);
      check("lat_w_idx", bus.w_idx, 0);
      check("lat_w0", bus.w_data, exp_w[0]);
   endtask

   // Consumes words, comparing every sampled cycle (stalls included) against
   // the expected word t. Returns early when word stop_at is on the outputs.
   task automatic drain(input bit rand_ready, input bit toggle_blk, input int stop_at);
      int t      = 0;
      int cycles = 0;
      bit rdy;
      while (t < 64) begin
         @(negedge clk);
         cycles++;
         if (cycles > 2000) begin
            check("drain_timeout", t, 64);
            bus.w_ready = 1'b0;
            return;
         end
         if (bus.w_valid) begin
            check("w_idx", bus.w_idx, t);
            check("w_data", bus.w_data, exp_w[t]);
            check("k_data", bus.k_data, k_ref[t]);
            check("w_last", bus.w_last, (t == 63));
            check("run_blk_ready", bus.blk_ready, 0);
            if (t == stop_at) begin
               bus.w_ready = 1'b0;
               return;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy) begin
               got_w[t] = bus.w_data;
               t++;
            end
            bus.w_ready = rdy;
         end else begin
            bus.w_ready = 1'b0;
         end
         if (toggle_blk) bus.blk_valid = (t == 64) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.w_ready   = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_blk_ready", bus.blk_ready, 1);
      check("rst_w_valid", bus.w_valid, 0);
      check("rst_w_idx", bus.w_idx, 0);
      check("rst_w_data", bus.w_data, 0);
      check("rst_k_data", bus.k_data, 32'h428a2f98);
      check("rst_w_last", bus.w_last, 0);
      @(negedge clk);
      rst = 1'b0;

      // "abc" block, consumer always ready
      blk_abc = '0;
      blk_abc[511:480] = 32'h61626380;
      blk_abc[31:0]    = 32'h00000018;
      send_block(blk_abc);
      drain(1'b0, 1'b0, 64);
      check("abc_w0",  got_w[0],  32'h61626380);
      check("abc_w15", got_w[15], 32'h00000018);
      check("abc_w16", got_w[16], 32'h61626380);
      check("abc_w17", got_w[17], 32'h000f0000);
      @(negedge clk);
      check("abc_end_w_valid", bus.w_valid, 0);

      // Same block under random backpressure
      send_block(blk_abc);
      drain(1'b1, 1'b0, 64);
      check("bp_w17", got_w[17], 32'h000f0000);

      // Back-to-back blocks with blk_valid held high
      blk_a = rand_block();
      blk_b = rand_block();
      build_exp(blk_a);
      @(negedge clk);
      bus.w_ready   = 1'b0;
      bus.blk_data  = blk_a;
      bus.blk_valid = 1'b1;
      @(posedge clk);
      #1 bus.blk_data = blk_b;
      drain(1'b0, 1'b0, 64);
      build_exp(blk_b);
      @(negedge clk);
      check("b2b_idle_blk_ready", bus.blk_ready, 1);
      check("b2b_idle_w_valid", bus.w_valid, 0);
      bus.w_ready = 1'b0;
      @(posedge clk);
      #1 bus.blk_valid = 1'b0;
      @(negedge clk);
      check("b2b_w_valid", bus.w_valid, 1);
      check("b2b_w_idx", bus.w_idx, 0);
      check("b2b_w0", bus.w_data, exp_w[0]);
      drain(1'b0, 1'b0, 64);

      // Reset asserted while word 30 is on the outputs
      blk_c = rand_block();
      send_block(blk_c);
      drain(1'b0, 1'b0, 30);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_w_valid", bus.w_valid, 0);
      check("mid_rst_blk_ready", bus.blk_ready, 1);
      check("mid_rst_w_idx", bus.w_idx, 0);
      check("mid_rst_w_data", bus.w_data, 0);
      check("mid_rst_k_data", bus.k_data, 32'h428a2f98);
      @(negedge clk);
      rst = 1'b0;
      blk_d = rand_block();
      send_block(blk_d);
      drain(1'b0, 1'b0, 64);

      // blk_valid toggling during RUN is ignored
      send_block(blk_abc);
      drain(1'b1, 1'b1, 64);
      @(negedge clk);
      check("tog_end_blk_ready", bus.blk_ready, 1);
      check("tog_end_w_valid", bus.w_valid, 0);
      @(negedge clk);
      check("tog_idle_w_valid", bus.w_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Message-schedule generator for the SHA-256 engine: accepts one 512-bit padded message block and streams the 64 schedule words W0..W63, each paired with its round constant K0..K63, to the round datapath. It is the producer side of the round's Kj/Wj inputs. The round controller consumes one (W, K) pair per accepted transfer.

## Interface
- `WORDSIZE`, default 32: schedule word width; only 32 is supported.
- `ROUNDS`, default 64: number of words emitted per block.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `blk_valid` in 1: a block is offered on `blk_data`.
- `blk_ready` out 1: the block can be accepted.
- `blk_data` in 512: padded block; M0 at [511:480], M15 at [31:0], big-endian words.
- `w_valid` out 1: `w_data`, `k_data`, `w_idx` and `w_last` are valid.
- `w_ready` in 1: the consumer takes the current word.
- `w_data` out 32: schedule word Wt.
- `k_data` out 32: round constant Kt.
- `w_idx` out 6: t, 0..63.
- `w_last` out 1: high when t == 63.

## Operation
- The window is 16 registers, win[0]..win[15], with win[0] as the current Wt.
- FSM has two states, IDLE and RUN.
- **IDLE:**
  - `blk_ready`=1, `w_valid`=0.
  - On `blk_valid && blk_ready`: win[i] ← M_i, idx ← 0, go to RUN.
- **RUN:**
  - `blk_ready`=0, `w_valid`=1.
  - Outputs: `w_data`=win[0], `k_data`=K[idx], `w_idx`=idx, `w_last`=(idx==63).
  - On `w_valid && w_ready` with idx<63: win[i] ← win[i+1] for i=0..14; win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32; idx ← idx+1.
  - On `w_valid && w_ready` with idx==63: go to IDLE. Window contents are don't-care.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- All additions are 32-bit wrap-around; carries are discarded.
- Backpressure: while `w_valid && !w_ready`, all outputs and the window hold unchanged.
- `blk_valid` in RUN is ignored; the block stays unaccepted until IDLE.
- The new word for t≥16 is computed combinationally from registered window values, so no extra pipeline stage is used.

## Timing
- Reset values: state=IDLE, idx=0, window=0.
  - `blk_ready`=1, `w_valid`=0, `w_data`=0, `k_data`=0x428a2f98, `w_idx`=0, `w_last`=0.
- Latency: block accepted at edge N; W0 is valid in the cycle after edge N.
- Throughput with `w_ready` held high: 64 consecutive cycles of `w_valid`, one IDLE cycle, then the next block. Minimum period is 65 cycles per block.
- Reset asserted mid-block: the block is abandoned immediately (asynchronously) and all outputs go to their reset values. After deassertion the block is in IDLE with `blk_ready`=1. No partial words are emitted.
- Simultaneous last-word handshake and `blk_valid`: the block is not taken that cycle. It is taken in the following IDLE cycle.

## Structure
- Shared package `sha256_pkg`:
  - K[0:63] constant table.
  - `SHA256_WORDSIZE` = 32.
  - Block width of 512.
  - Localparams for the state encoding.
- Sub-module `sha256_sched_sigma`: combinational σ0/σ1 for the small sigmas, next to the existing big-sigma blocks.
- The top level holds the FSM, counter, window and K lookup.

## Test plan
- Reset sequence -> `blk_ready`=1, `w_valid`=0, `w_idx`=0, `k_data`=0x428a2f98.
- "abc" padded block (M0=0x61626380, M15=0x00000018, all others 0) with `w_ready`=1:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - K63=0xc67178f2 with `w_last`=1 at t=63.
  - All 64 words match the golden model.
- Random `w_ready` backpressure on the same block -> identical W/K sequence, and outputs stable on every stall cycle.
- Two back-to-back random blocks with `blk_valid` held high -> second block accepted exactly one cycle after the t=63 handshake. Each block's 64 words match the model; no word is lost or duplicated.
- `rst` pulsed while `w_idx`=30 -> `w_valid` drops the same cycle. After release, a new block restarts at `w_idx`=0 with correct W0.
- `blk_valid` toggled during RUN -> ignored; `blk_ready` stays 0 until IDLE.
